// File: rtl/ps2_keys_pkg.sv
// PS/2 break-code constants, FSM state and key-class types for hex entry.
package ps2_keys_pkg;

  localparam logic [15:0] K_0 = 16'hF045;
  localparam logic [15:0] K_1 = 16'hF016;
  localparam logic [15:0] K_2 = 16'hF01E;
  localparam logic [15:0] K_3 = 16'hF026;
  localparam logic [15:0] K_4 = 16'hF025;
  localparam logic [15:0] K_5 = 16'hF02E;
  localparam logic [15:0] K_6 = 16'hF036;
  localparam logic [15:0] K_7 = 16'hF03D;
  localparam logic [15:0] K_8 = 16'hF03E;
  localparam logic [15:0] K_9 = 16'hF046;
  localparam logic [15:0] K_A = 16'hF01C;
  localparam logic [15:0] K_B = 16'hF032;
  localparam logic [15:0] K_C = 16'hF021;
  localparam logic [15:0] K_D = 16'hF023;
  localparam logic [15:0] K_E = 16'hF024;
  localparam logic [15:0] K_F = 16'hF02B;

  localparam logic [15:0] K_ENTER = 16'hF05A;
  localparam logic [15:0] K_BS    = 16'hF066;
  localparam logic [15:0] K_ESC   = 16'hF076;

  localparam logic [15:0] KP_0 = 16'hF070;
  localparam logic [15:0] KP_1 = 16'hF069;
  localparam logic [15:0] KP_2 = 16'hF072;
  localparam logic [15:0] KP_3 = 16'hF07A;
  localparam logic [15:0] KP_4 = 16'hF06B;
  localparam logic [15:0] KP_5 = 16'hF073;
  localparam logic [15:0] KP_6 = 16'hF074;
  localparam logic [15:0] KP_7 = 16'hF06C;
  localparam logic [15:0] KP_8 = 16'hF075;
  localparam logic [15:0] KP_9 = 16'hF07D;

  typedef enum logic [1:0] {EMPTY, ENTRY, HOLD} state_t;

  typedef enum logic [2:0] {KEY_HEX, KEY_ENTER, KEY_BS, KEY_ESC, KEY_NONE} key_class_t;

endpackage

// File: rtl/ps2_hex_decode.sv
// Combinational break-code classifier: code -> {key class, hex nibble}.
// Define HEX_ENTRY_KEYPAD_EN to also accept numeric keypad digits.
module ps2_hex_decode
  import ps2_keys_pkg::*;
(
  input  logic [15:0] code,
  output key_class_t  cls,
  output logic [3:0]  nib
);

  // Map a break code onto its key class; nibble is only meaningful for KEY_HEX
  always_comb begin
    cls = KEY_HEX;
    nib = 4'h0;
    case (code)
      K_0: nib = 4'h0;
      K_1: nib = 4'h1;
      K_2: nib = 4'h2;
      K_3: nib = 4'h3;
      K_4: nib = 4'h4;
      K_5: nib = 4'h5;
      K_6: nib = 4'h6;
      K_7: nib = 4'h7;
      K_8: nib = 4'h8;
      K_9: nib = 4'h9;
      K_A: nib = 4'hA;
      K_B: nib = 4'hB;
      K_C: nib = 4'hC;
      K_D: nib = 4'hD;
      K_E: nib = 4'hE;
      K_F: nib = 4'hF;
`ifdef HEX_ENTRY_KEYPAD_EN
      KP_0: nib = 4'h0;
      KP_1: nib = 4'h1;
      KP_2: nib = 4'h2;
      KP_3: nib = 4'h3;
      KP_4: nib = 4'h4;
      KP_5: nib = 4'h5;
      KP_6: nib = 4'h6;
      KP_7: nib = 4'h7;
      KP_8: nib = 4'h8;
      KP_9: nib = 4'h9;
`endif
      K_ENTER: cls = KEY_ENTER;
      K_BS:    cls = KEY_BS;
      K_ESC:   cls = KEY_ESC;
      default: cls = KEY_NONE;
    endcase
  end

endmodule

// File: rtl/ps2_hex_entry.sv
// Multi-digit hex entry: repeat-suppressed key events edit a right-aligned
// digit buffer; Enter hands the value to the CPU over valid/ready.
// Optional keypad digits via HEX_ENTRY_KEYPAD_EN (handled in ps2_hex_decode).
module ps2_hex_entry
  import ps2_keys_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [15:0]                  code,
  input  logic                         code_valid,
  output logic [4*DIGITS-1:0]          value,
  output logic                         value_valid,
  input  logic                         value_ready,
  output logic [3:0]                   digit,
  output logic                         digit_stb,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         overflow
);

  localparam int VW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  state_t          state_q, state_d;
  logic [15:0]     last_code;
  logic [VW-1:0]   acc, acc_d, value_d;
  logic [CW-1:0]   cnt_d;
  logic            vv_d, stb_d, ovf_d;
  logic [3:0]      digit_d;
  key_class_t      cls;
  logic [3:0]      nib;
  logic            key_ev;

  ps2_hex_decode u_dec (.code(code), .cls(cls), .nib(nib));

  // A held key only counts once; dropping code_valid re-arms the detector
  assign key_ev = code_valid && (code != last_code);

  // Repeat-suppression history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          last_code <= 16'h0000;
    else if (code_valid) last_code <= code;
    else                 last_code <= 16'h0000;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next state and next datapath/output values
  always_comb begin
    state_d = state_q;
    acc_d   = acc;
    cnt_d   = digit_count;
    value_d = value;
    vv_d    = value_valid;
    digit_d = digit;
    stb_d   = 1'b0;
    ovf_d   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (key_ev && cls == KEY_HEX) begin
          acc_d   = VW'(nib);
          cnt_d   = CW'(1);
          digit_d = nib;
          stb_d   = 1'b1;
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        if (key_ev) begin
          case (cls)
            KEY_HEX: begin
              if (digit_count < CW'(DIGITS)) begin
                acc_d   = (acc << 4) | VW'(nib);
                cnt_d   = digit_count + CW'(1);
                digit_d = nib;
                stb_d   = 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
            end
            KEY_BS: begin
              acc_d = acc >> 4;
              cnt_d = digit_count - CW'(1);
              if (digit_count == CW'(1)) state_d = EMPTY;
            end
            KEY_ESC: begin
              acc_d   = '0;
              cnt_d   = '0;
              state_d = EMPTY;
            end
            KEY_ENTER: begin
              value_d = acc;
              vv_d    = 1'b1;
              state_d = HOLD;
            end
            default: ;
          endcase
        end
      end
      HOLD: begin
        // Key events here are dropped, including one coinciding with the handshake
        if (value_ready) begin
          vv_d    = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      digit_count <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      digit       <= 4'h0;
      digit_stb   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      acc         <= acc_d;
      digit_count <= cnt_d;
      value       <= value_d;
      value_valid <= vv_d;
      digit       <= digit_d;
      digit_stb   <= stb_d;
      overflow    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ps2_hex_entry.sv
// Self-checking bench for ps2_hex_entry: directed scenarios then random keys,
// every cycle compared against a digit-list reference model.
module tb_ps2_hex_entry;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] code = 16'h0;
  logic        code_valid = 1'b0;
  logic        value_ready = 1'b0;
  logic [15:0] value;
  logic        value_valid;
  logic [3:0]  digit;
  logic        digit_stb;
  logic [2:0]  digit_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  ps2_hex_entry #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .code(code), .code_valid(code_valid),
    .value(value), .value_valid(value_valid), .value_ready(value_ready),
    .digit(digit), .digit_stb(digit_stb), .digit_count(digit_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Key tables indexed by digit value
  logic [15:0] hex_tab [16] = '{16'hF045, 16'hF016, 16'hF01E, 16'hF026,
                                16'hF025, 16'hF02E, 16'hF036, 16'hF03D,
                                16'hF03E, 16'hF046, 16'hF01C, 16'hF032,
                                16'hF021, 16'hF023, 16'hF024, 16'hF02B};
  logic [15:0] kp_tab [10]  = '{16'hF070, 16'hF069, 16'hF072, 16'hF07A,
                                16'hF06B, 16'hF073, 16'hF074, 16'hF06C,
                                16'hF075, 16'hF07D};

  // Reference model: list of held digits plus handshake flag
  int          m_q[$];
  logic [15:0] m_last = 16'h0;
  logic        m_hold = 1'b0;
  logic [15:0] m_value = 16'h0;
  logic [3:0]  m_digit = 4'h0;
  logic        m_stb = 1'b0;
  logic        m_ovf = 1'b0;

  // 0 hex, 1 enter, 2 backspace, 3 escape, 4 other
  function automatic int classify(input logic [15:0] c, output int n);
    n = 0;
    for (int i = 0; i < 16; i++) if (hex_tab[i] == c) begin n = i; return 0; end
`ifdef HEX_ENTRY_KEYPAD_EN
    for (int i = 0; i < 10; i++) if (kp_tab[i] == c) begin n = i; return 0; end
`endif
    if (c == 16'hF05A) return 1;
    if (c == 16'hF066) return 2;
    if (c == 16'hF076) return 3;
    return 4;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_last = 16'h0; m_hold = 1'b0; m_value = 16'h0;
    m_digit = 4'h0; m_stb = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model(input logic [15:0] c, input logic v, input logic r);
    bit ev;
    int k, n;
    ev = v && (c != m_last);
    m_last = v ? c : 16'h0;
    m_stb = 1'b0;
    m_ovf = 1'b0;
    if (m_hold) begin
      if (r) begin m_hold = 1'b0; m_q.delete(); end
    end else if (ev) begin
      k = classify(c, n);
      case (k)
        0: if (m_q.size() < DIGITS) begin
             m_q.push_back(n); m_digit = 4'(n); m_stb = 1'b1;
           end else m_ovf = 1'b1;
        1: if (m_q.size() > 0) begin
             m_value = 16'h0;
             foreach (m_q[i]) m_value = m_value * 16 + 16'(m_q[i]);
             m_hold = 1'b1;
           end
        2: if (m_q.size() > 0) void'(m_q.pop_back());
        3: m_q.delete();
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("value",       32'(value),       32'(m_value));
    chk("value_valid", 32'(value_valid), 32'(m_hold));
    chk("digit",       32'(digit),       32'(m_digit));
    chk("digit_stb",   32'(digit_stb),   32'(m_stb));
    chk("digit_count", 32'(digit_count), 32'(m_q.size()));
    chk("overflow",    32'(overflow),    32'(m_ovf));
  endtask

  task automatic step(input logic [15:0] c, input logic v, input logic r);
    @(negedge clk);
    code = c; code_valid = v; value_ready = r;
    model(c, v, r);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic key(input logic [15:0] c);
    step(c, 1'b1, 1'b0);
  endtask

  int stb_seen;

  initial begin
    logic [15:0] c, prev;
    logic        v, r;
    int          sel;

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic entry 1,2,A then Enter, held until ready
    stb_seen = 0;
    key(16'hF016); stb_seen += digit_stb;
    key(16'hF01E); stb_seen += digit_stb;
    key(16'hF01C); stb_seen += digit_stb;
    chk("three_stb", 32'(stb_seen), 32'd3);
    chk("digit_A", 32'(digit), 32'hA);
    key(16'hF05A);
    chk("value_012A", 32'(value), 32'h012A);
    chk("vv_set", 32'(value_valid), 32'd1);
    step(16'h0, 1'b0, 1'b0);
    step(16'h0, 1'b0, 1'b0);
    chk("vv_held", 32'(value_valid), 32'd1);
    step(16'h0, 1'b0, 1'b1);
    chk("vv_drop", 32'(value_valid), 32'd0);
    chk("count_zero", 32'(digit_count), 32'd0);

    // Held key gives exactly one digit
    step(16'h0, 1'b0, 1'b0);
    stb_seen = 0;
    repeat (10) begin key(16'hF026); stb_seen += digit_stb; end
    chk("held_one_stb", 32'(stb_seen), 32'd1);
    chk("held_digit", 32'(digit), 32'd3);
    chk("held_count", 32'(digit_count), 32'd1);
    key(16'hF076);

    // Overflow on fifth digit
    key(16'hF016); key(16'hF01E); key(16'hF026); key(16'hF025);
    key(16'hF02E);
    chk("overflow_5th", 32'(overflow), 32'd1);
    key(16'hF05A);
    chk("value_1234", 32'(value), 32'h1234);
    step(16'h0, 1'b0, 1'b1);

    // Backspace editing
    key(16'hF016); key(16'hF01E); key(16'hF026); key(16'hF066);
    key(16'hF046); key(16'hF05A);
    chk("value_0129", 32'(value), 32'h0129);
    step(16'h0, 1'b0, 1'b1);

    // Escape then Enter gives nothing
    key(16'hF03D); key(16'hF076);
    chk("esc_count", 32'(digit_count), 32'd0);
    key(16'hF05A);
    chk("enter_empty", 32'(value_valid), 32'd0);

    // HOLD ignores keys; event on handshake cycle is dropped
    key(16'hF025); key(16'hF05A);
    key(16'hF016);
    chk("hold_value", 32'(value), 32'h0004);
    chk("hold_no_stb", 32'(digit_stb), 32'd0);
    step(16'hF01E, 1'b1, 1'b1);
    chk("hs_vv", 32'(value_valid), 32'd0);
    chk("hs_discard", 32'(digit_stb), 32'd0);
    key(16'hF026);
    chk("after_hs_stb", 32'(digit_stb), 32'd1);
    chk("after_hs_digit", 32'(digit), 32'd3);
    key(16'hF076);

    // Keypad digit
    key(16'hF069); key(16'hF05A);
`ifdef HEX_ENTRY_KEYPAD_EN
    chk("kp_value", 32'(value), 32'h0001);
    chk("kp_vv", 32'(value_valid), 32'd1);
    step(16'h0, 1'b0, 1'b1);
`else
    chk("kp_vv_off", 32'(value_valid), 32'd0);
`endif

    // Asynchronous reset while in HOLD
    key(16'hF02B); key(16'hF05A);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    prev = 16'h0;
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1, 2, 3, 4: c = hex_tab[$urandom_range(0, 15)];
        5:             c = 16'hF05A;
        6:             c = 16'hF066;
        7:             c = 16'hF076;
        8:             c = kp_tab[$urandom_range(0, 9)];
        9:             c = 16'($urandom());
        default:       c = prev;
      endcase
      v = ($urandom_range(0, 4) != 0);
      r = ($urandom_range(0, 3) == 0);
      step(c, v, r);
      prev = c;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_hex_entry.md
# ps2_hex_entry

Multi-digit hexadecimal entry block for the PS/2 keyboard path. It takes 16-bit break codes from the PS/2 receiver and suppresses repeated codes. It accumulates up to DIGITS hex digits into a right-aligned value, with backspace and clear editing. On Enter it presents the completed value to the CPU input port through a valid/ready handshake.

## Interface
- DIGITS, 4, maximum number of hex digits held; value width is 4*DIGITS; legal range 1..8
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- code  input  16  latest code from the PS/2 receiver, {prefix byte, key byte}
- code_valid  input  1  code is meaningful this cycle
- value  output  4*DIGITS  committed value, zero-extended, newest digit in the LSB nibble
- value_valid  output  1  value is presented and stable
- value_ready  input  1  consumer accepts value
- digit  output  4  most recently accepted digit
- digit_stb  output  1  one-cycle pulse when a digit is appended
- digit_count  output  $clog2(DIGITS+1)  digits currently held
- overflow  output  1  one-cycle pulse when a digit is dropped because the buffer is full

## Operation
- Key event: code_valid=1 and code differs from last_code.
  - last_code is loaded with code every cycle in which code_valid=1.
  - last_code is cleared to 16'h0000 when code_valid=0.
  - Holding the same code produces exactly one event.
- Hex keys are break codes: 1..9,0 = F016,F01E,F026,F025,F02E,F036,F03D,F03E,F046,F045; A..F = F01C,F032,F021,F023,F024,F02B.
- Control keys: Enter F05A, Backspace F066, Escape F076. All other codes are ignored and still update last_code.
- States:
  - EMPTY (count=0): a hex key goes to ENTRY. Enter, Backspace and Escape are ignored.
  - ENTRY:
    - Hex key with count<DIGITS: acc={acc[4*DIGITS-5:0],nibble}, count+1, digit_stb pulse.
    - Hex key with count==DIGITS: acc unchanged, overflow pulse.
    - Backspace: acc>>=4, count-1; goes to EMPTY if count reaches 0.
    - Escape: acc=0, count=0, go to EMPTY.
    - Enter: value=acc, value_valid=1, go to HOLD.
  - HOLD: all key events are ignored, though last_code keeps tracking. value_valid stays high and value stays stable until value_ready=1. Then value_valid=0, acc=0, count=0, go to EMPTY.
- Reset: state EMPTY, last_code=0, acc=0, value=0, value_valid=0, digit=0, digit_stb=0, digit_count=0, overflow=0.

## Timing
- All outputs are registered.
- An event in cycle N updates digit, digit_stb, digit_count and overflow at edge N+1.
- Enter in cycle N asserts value_valid at edge N+1.
- Handshake completes in the cycle where value_valid and value_ready are both 1. value_valid drops at the next edge.
- value_ready asserted while value_valid=0 has no effect.
- A key event in the same cycle as handshake completion is discarded. The next distinct code is processed normally.
- An asynchronous reset mid-entry or mid-HOLD drops the pending value with no handshake.
- Sustained throughput is one key event per cycle.

## Configuration
- HEX_ENTRY_KEYPAD_EN defined: numeric keypad break codes also map to digits 0..9. These are F070,F069,F072,F07A,F06B,F073,F074,F06C,F075,F07D.
- HEX_ENTRY_KEYPAD_EN undefined: keypad codes are treated as unknown and ignored. Main-row behaviour is identical either way.

## Structure
- Package ps2_keys_pkg holds:
  - Break-code constants for all hex, control and keypad keys.
  - The state enum (EMPTY, ENTRY, HOLD).
  - A key-class enum (KEY_HEX, KEY_ENTER, KEY_BS, KEY_ESC, KEY_NONE).
- Sub-module ps2_hex_decode is purely combinational: code in, {key class, nibble} out. It contains the HEX_ENTRY_KEYPAD_EN guard.
- ps2_hex_entry contains the event detector, the FSM, the accumulator and the output registers.

## Test plan
- DIGITS=4. Pulse code_valid with F016, F01E, F01C, then F05A. Required: digit_stb three times (1,2,A), then value=16'h012A, value_valid=1 held until value_ready, then digit_count=0.
- Hold code=F026 with code_valid=1 for 10 cycles. Required: exactly one digit_stb with digit=3 and digit_count=1.
- Enter 5 digits 1,2,3,4,5 with DIGITS=4. Required: the fifth digit gives an overflow pulse; Enter gives value=16'h1234.
- Enter 1,2,3, then Backspace, then 9, then Enter. Required: value=16'h0129. Escape after any digits gives digit_count=0, and a following Enter gives no value_valid.
- In HOLD with value_ready=0, send F016. Required: value unchanged and no digit_stb. Then assert value_ready in the same cycle as a new event. Required: value_valid drops, that event is discarded, and the next distinct code is accepted.
- With HEX_ENTRY_KEYPAD_EN, F069 then F05A gives value=16'h0001. Without the macro, the same stimulus gives no digit_stb and no value_valid. Asserting rst_n low while in HOLD clears all outputs immediately.
